// File: rtl/line_scan_point_emulator.sv
// Synthetic line-scan sensor: dark prefix, colour region and three blinking
// bright-point windows, emitted as registered 8-bit pixels with a pixel clock.
module line_scan_point_emulator #(
   parameter int TAP_DARK_PIXELS_COUNT  = 16,
   parameter int TAP_COLOR_PIXELS_COUNT = 1024,
   parameter int PIXEL0_INDEX           = 2,
   parameter int PIXEL1_INDEX           = 256,
   parameter int PIXEL2_INDEX           = 768,
   parameter int POINT_WIDTH_PIXELS     = 32,
   parameter int PIXEL_DIVIDER          = 4,
   parameter int CLOCK_FREQUENCY        = 100000000,
   parameter int POINT0_FREQUENCY       = 5000,
   parameter int POINT1_FREQUENCY       = 15000,
   parameter int POINT2_FREQUENCY       = 25000,
   parameter int BRIGHT_LEVEL           = 200,
   parameter int BACKGROUND_LEVEL       = 32,
   parameter int DARK_LEVEL             = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [31:0] half_period0,
   input  logic [31:0] half_period1,
   input  logic [31:0] half_period2,
   output logic [7:0]  data,
   output logic        pixel_clock,
   output logic        line_start,
   output logic [2:0]  point_state,
   output logic [31:0] line_counter
);

   localparam int N_SLOTS = TAP_DARK_PIXELS_COUNT + TAP_COLOR_PIXELS_COUNT;
   localparam int DIV_W   = (PIXEL_DIVIDER > 2) ? $clog2(PIXEL_DIVIDER) : 1;

   localparam logic [11:0] LAST_SLOT  = 12'(N_SLOTS);
   localparam logic [11:0] DARK_END   = 12'(TAP_DARK_PIXELS_COUNT);
   localparam logic [11:0] WIN0_START = 12'(TAP_DARK_PIXELS_COUNT + PIXEL0_INDEX);
   localparam logic [11:0] WIN1_START = 12'(TAP_DARK_PIXELS_COUNT + PIXEL1_INDEX);
   localparam logic [11:0] WIN2_START = 12'(TAP_DARK_PIXELS_COUNT + PIXEL2_INDEX);
   localparam logic [11:0] WIN0_END   = 12'(TAP_DARK_PIXELS_COUNT + PIXEL0_INDEX + POINT_WIDTH_PIXELS);
   localparam logic [11:0] WIN1_END   = 12'(TAP_DARK_PIXELS_COUNT + PIXEL1_INDEX + POINT_WIDTH_PIXELS);
   localparam logic [11:0] WIN2_END   = 12'(TAP_DARK_PIXELS_COUNT + PIXEL2_INDEX + POINT_WIDTH_PIXELS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIVIDER - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIXEL_DIVIDER / 2);

   localparam logic [31:0] HP0_DEFAULT = 32'(CLOCK_FREQUENCY / (2 * POINT0_FREQUENCY));
   localparam logic [31:0] HP1_DEFAULT = 32'(CLOCK_FREQUENCY / (2 * POINT1_FREQUENCY));
   localparam logic [31:0] HP2_DEFAULT = 32'(CLOCK_FREQUENCY / (2 * POINT2_FREQUENCY));

   logic [DIV_W-1:0] div_r, div_next_s;
   logic [11:0]      pix_r, pix_next_s;
   logic [31:0]      hp_r [3];
   logic [31:0]      cnt_r [3];
   logic [31:0]      cnt_next_s [3];
   logic [31:0]      hp_in_s [3];
   logic [2:0]       ps_r, ps_next_s;
   logic [7:0]       data_r;
   logic             pixel_clock_r, line_start_r;
   logic [31:0]      line_counter_r;
   logic             slot_start_s, line_begin_s;

   function automatic logic in_window(input logic [11:0] pix, input logic [11:0] lo,
                                      input logic [11:0] hi);
      return (pix >= lo) && (pix < hi);
   endfunction

   function automatic logic [7:0] pixel_level(input logic [11:0] pix, input logic [2:0] ps);
      logic bright;
      bright = (ps[0] & in_window(pix, WIN0_START, WIN0_END)) |
               (ps[1] & in_window(pix, WIN1_START, WIN1_END)) |
               (ps[2] & in_window(pix, WIN2_START, WIN2_END));
      if ((pix < DARK_END) || (pix == LAST_SLOT)) begin
         return 8'(DARK_LEVEL);
      end else if (bright) begin
         return 8'(BRIGHT_LEVEL);
      end else begin
         return 8'(BACKGROUND_LEVEL);
      end
   endfunction

   assign hp_in_s[0]   = half_period0;
   assign hp_in_s[1]   = half_period1;
   assign hp_in_s[2]   = half_period2;
   assign slot_start_s = (div_r == {DIV_W{1'b0}});
   assign line_begin_s = enable & slot_start_s & (pix_r == 12'd0);

   // Divider and slot position; idle forces both back to the line origin.
   always_comb begin
      div_next_s = div_r;
      pix_next_s = pix_r;
      if (!enable) begin
         div_next_s = {DIV_W{1'b0}};
         pix_next_s = 12'd0;
      end else if (div_r == DIV_LAST) begin
         div_next_s = {DIV_W{1'b0}};
         pix_next_s = (pix_r == LAST_SLOT) ? 12'd0 : pix_r + 12'd1;
      end else begin
         div_next_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
         pix_next_s = pix_r;
      end
   end

   // Blink generators: load wins over a coincident toggle; zero half-period parks the point off.
   always_comb begin
      ps_next_s = ps_r;
      for (int k = 0; k < 3; k++) begin
         cnt_next_s[k] = cnt_r[k];
         if (load) begin
            cnt_next_s[k] = 32'd0;
            ps_next_s[k]  = 1'b0;
         end else if (!enable) begin
            cnt_next_s[k] = cnt_r[k];
         end else if (hp_r[k] == 32'd0) begin
            cnt_next_s[k] = 32'd0;
            ps_next_s[k]  = 1'b0;
         end else if (cnt_r[k] == hp_r[k] - 32'd1) begin
            cnt_next_s[k] = 32'd0;
            ps_next_s[k]  = ~ps_r[k];
         end else begin
            cnt_next_s[k] = cnt_r[k] + 32'd1;
         end
      end
   end

   // Timing state and blink state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_r    <= {DIV_W{1'b0}};
         pix_r    <= 12'd0;
         ps_r     <= 3'd0;
         hp_r[0]  <= HP0_DEFAULT;
         hp_r[1]  <= HP1_DEFAULT;
         hp_r[2]  <= HP2_DEFAULT;
         for (int k = 0; k < 3; k++) cnt_r[k] <= 32'd0;
      end else begin
         div_r <= div_next_s;
         pix_r <= pix_next_s;
         ps_r  <= ps_next_s;
         for (int k = 0; k < 3; k++) begin
            cnt_r[k] <= cnt_next_s[k];
            hp_r[k]  <= load ? hp_in_s[k] : hp_r[k];
         end
      end
   end

   // Registered pixel outputs; window pixels use the blink state that is visible during d=0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_r         <= 8'd0;
         pixel_clock_r  <= 1'b0;
         line_start_r   <= 1'b0;
         line_counter_r <= 32'd0;
      end else if (!enable) begin
         data_r         <= 8'd0;
         pixel_clock_r  <= 1'b0;
         line_start_r   <= 1'b0;
         line_counter_r <= line_counter_r;
      end else begin
         data_r         <= slot_start_s ? pixel_level(pix_r, ps_next_s) : data_r;
         pixel_clock_r  <= (div_r >= DIV_HALF);
         line_start_r   <= line_begin_s;
         line_counter_r <= line_begin_s ? line_counter_r + 32'd1 : line_counter_r;
      end
   end

   assign data         = data_r;
   assign pixel_clock  = pixel_clock_r;
   assign line_start   = line_start_r;
   assign point_state  = ps_r;
   assign line_counter = line_counter_r;

endmodule

// File: tb/tb_line_scan_point_emulator.sv
// Bench for line_scan_point_emulator: a time-indexed reference model checked
// every cycle, plus directed literal checks of periods, slot levels and reset.
module tb_line_scan_point_emulator;

   localparam int DARK  = 16;
   localparam int NS    = 1040;
   localparam int DIV   = 4;
   localparam int LINE  = (NS + 1) * DIV;
   localparam int WIDTH = 32;
   localparam int IDX [3] = '{2, 256, 768};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [31:0] half_period0 = 32'd0, half_period1 = 32'd0, half_period2 = 32'd0;
   logic [7:0]  data;
   logic        pixel_clock, line_start;
   logic [2:0]  point_state;
   logic [31:0] line_counter;

   int     compared = 0;
   int     mismatched = 0;
   longint cyc_n = 0;

   // reference model state
   longint     t_m = 0;
   bit         run_m = 1'b0;
   longint     hp_m [3] = '{10000, 3333, 2000};
   longint     el_m [3] = '{0, 0, 0};
   logic [2:0] ps_m = 3'd0;
   logic [7:0] data_m = 8'd0;
   logic       pclk_m = 1'b0, ls_m = 1'b0;
   logic [31:0] lc_m = 32'd0;

   line_scan_point_emulator dut (
      .clock(clock), .reset(reset), .enable(enable), .load(load),
      .half_period0(half_period0), .half_period1(half_period1), .half_period2(half_period2),
      .data(data), .pixel_clock(pixel_clock), .line_start(line_start),
      .point_state(point_state), .line_counter(line_counter)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cyc_n <= cyc_n + 1;

   function automatic logic [7:0] exp_level(input longint slot, input logic [2:0] ps);
      if (slot < DARK || slot == NS) return 8'd16;
      for (int k = 0; k < 3; k++)
         if (ps[k] && slot >= DARK + IDX[k] && slot < DARK + IDX[k] + WIDTH) return 8'd200;
      return 8'd32;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
   endtask

   // Reference model: outputs are a function of the cycle index since enable rose.
   initial forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
         run_m = 1'b0; t_m = 0; ps_m = 3'd0; data_m = 8'd0; pclk_m = 1'b0; ls_m = 1'b0;
         lc_m = 32'd0; hp_m = '{10000, 3333, 2000}; el_m = '{0, 0, 0};
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (load) begin
               hp_m[k] = (k == 0) ? half_period0 : (k == 1) ? half_period1 : half_period2;
               el_m[k] = 0;
            end else if (enable) el_m[k]++;
            ps_m[k] = (hp_m[k] == 0) ? 1'b0 : 1'((el_m[k] / hp_m[k]) % 2);
         end
         if (enable) begin
            if (run_m) t_m++;
            else begin t_m = 0; run_m = 1'b1; end
            pclk_m = ((t_m % DIV) >= DIV / 2);
            ls_m   = ((t_m % LINE) == 0);
            if (ls_m) lc_m = lc_m + 32'd1;
            if ((t_m % DIV) == 0) data_m = exp_level((t_m / DIV) % (NS + 1), ps_m);
         end else begin
            run_m = 1'b0; pclk_m = 1'b0; ls_m = 1'b0; data_m = 8'd0;
         end
      end
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clock);
      check("data", data, data_m);
      check("pixel_clock", pixel_clock, pclk_m);
      check("line_start", line_start, ls_m);
      check("point_state", point_state, ps_m);
      check("line_counter", line_counter, lc_m);
   end

   task automatic wait_ls();
      int i;
      for (i = 0; i < 6000; i++) begin
         @(negedge clock);
         if (line_start) break;
      end
      if (i == 6000) timeout("wait_line_start");
   endtask

   task automatic goto_slot(input int s);
      wait_ls();
      repeat (s * DIV) @(negedge clock);
   endtask

   task automatic wait_ps_change(input int bit_i, input int budget, output longint at);
      logic old;
      int i;
      old = point_state[bit_i];
      for (i = 0; i < budget; i++) begin
         @(negedge clock);
         if (point_state[bit_i] != old) break;
      end
      if (i == budget) timeout("wait_point_state");
      at = cyc_n;
   endtask

   initial begin
      longint a, b;
      int n, hi, bright_cnt, ps1_seen;

      repeat (5) @(negedge clock);
      check("rst_data", data, 0);
      check("rst_line_counter", line_counter, 0);
      check("rst_point_state", point_state, 0);

      // defaults
      reset = 1'b0; enable = 1'b1;
      @(negedge clock);
      check("first_line_start", line_start, 1);
      check("slot0_dark", data, 16);
      a = 0; b = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (pixel_clock && a == 0) a = cyc_n;
         else if (pixel_clock && a != 0 && b == 0 && cyc_n - a > 1) b = cyc_n;
      end
      check("pclk_period", b - a, 4);
      hi = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clock); hi += int'(pixel_clock); end
      check("pclk_high_count", hi, 4);
      wait_ls(); a = cyc_n;
      wait_ls(); b = cyc_n;
      check("line_period", b - a, LINE);
      @(negedge clock);
      check("line_counter_3", line_counter, 3);
      repeat (15 * DIV - 1) @(negedge clock);
      check("slot15_dark", data, 16);
      repeat (DIV) @(negedge clock);
      check("slot16_background", data, 32);
      repeat ((NS - 16) * DIV) @(negedge clock);
      check("slot1040_dark", data, 16);

      // fast blink on point 0, point 1 parked
      load = 1'b1; half_period0 = 32'd10; half_period1 = 32'd0; half_period2 = 32'd2000;
      @(negedge clock);
      load = 1'b0;
      wait_ps_change(0, 50, a);
      wait_ps_change(0, 50, b);
      check("ps0_toggle_interval", b - a, 10);
      goto_slot(17);
      check("slot17_background", data, 32);
      repeat (33 * DIV) @(negedge clock);
      check("slot50_background", data, 32);
      bright_cnt = 0; ps1_seen = 0;
      for (int i = 0; i < LINE; i++) begin
         @(negedge clock);
         if (data == 8'd200) bright_cnt++;
         if (point_state[1]) ps1_seen = 1;
      end
      check("window0_has_bright", (bright_cnt > 0) ? 1 : 0, 1);
      check("ps1_held_off", ps1_seen, 0);

      // reload point 2 exactly on its toggle edge
      load = 1'b1; half_period2 = 32'd7;
      @(negedge clock);
      load = 1'b0;
      @(posedge clock); #1;
      for (n = 0; n < 20; n++) begin
         if (el_m[2] % 7 == 6) break;
         @(posedge clock); #1;
      end
      if (n == 20) timeout("wait_toggle_edge");
      load = 1'b1;
      @(posedge clock); #1;
      load = 1'b0;
      check("ps2_after_load", point_state[2], 0);
      for (n = 1; n <= 20; n++) begin
         @(posedge clock); #1;
         if (point_state[2]) break;
      end
      check("ps2_first_toggle", n, 7);

      // enable drop mid-line
      goto_slot(500);
      enable = 1'b0;
      @(negedge clock);
      check("idle_data", data, 0);
      check("idle_pclk", pixel_clock, 0);
      repeat (7) @(negedge clock);
      enable = 1'b1;
      @(negedge clock);
      check("reenable_line_start", line_start, 1);
      check("reenable_slot0", data, 16);

      // randomized traffic
      for (int i = 0; i < 12000; i++) begin
         @(posedge clock); #1;
         n = $urandom_range(0, 999);
         if (n < 3) enable = ~enable;
         if (n >= 995) begin
            load = 1'b1;
            half_period0 = $urandom_range(0, 40);
            half_period1 = $urandom_range(0, 40);
            half_period2 = $urandom_range(0, 40);
         end else load = 1'b0;
      end
      @(posedge clock); #1;
      load = 1'b0; enable = 1'b1;
      repeat (50) @(posedge clock);

      // asynchronous reset mid-slot
      #1 reset = 1'b1;
      #1;
      check("async_rst_data", data, 0);
      check("async_rst_line_start", line_start, 0);
      check("async_rst_point_state", point_state, 0);
      check("async_rst_line_counter", line_counter, 0);
      #1 reset = 1'b0;
      for (n = 1; n <= 10100; n++) begin
         @(posedge clock); #1;
         if (point_state[0]) break;
      end
      check("default_half_period0", n, 10000);

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
